argmax_sequencer: RTL and testbench
===================================

# argmax_sequencer

Controller that sequences an argmax over a block of NPU output scores. It streams N signed 16-bit results from the output buffer, tracks the running maximum and its position, and reports the winning class index with a done pulse. It sits between the output buffer read port and the host/classification logic. It also drives the reset/enable strobes of the downstream comparator so that the comparator stays cycle-aligned with the read stream.

## Interface
- N_ITEMS, 10, number of scores per run (1 ≤ N_ITEMS ≤ 2^ADDR_W)
- ADDR_W, 8, buffer address and index width
- DATA_W, 16, score width (signed two's complement)

- CLK  in  1  single clock, all logic on posedge
- RST  in  1  synchronous, active-high reset
- START  in  1  run request, sampled in IDLE only
- BUSY  out  1  high from CLEAR through DRAIN
- DONE  out  1  one-cycle pulse, result valid
- RD_EN  out  1  buffer read strobe
- RD_ADDR  out  ADDR_W  buffer read address
- RD_DATA  in  DATA_W  buffer data, valid 1 cycle after RD_EN
- CMP_RST  out  1  comparator clear strobe
- CMP_EN  out  1  comparator enable, aligned with valid RD_DATA
- MAX_VAL  out  DATA_W  winning score
- MAX_IDX  out  ADDR_W  winning position (0-based)

## Operation
- FSM states: IDLE → CLEAR → READ → DRAIN → DONE → IDLE.
- IDLE:
  - START=1 → CLEAR.
  - START is ignored in every other state.
- CLEAR (1 cycle):
  - CMP_RST=1.
  - Running max = 16'sh8000, running idx = 0, address counter = 0.
- READ (N_ITEMS cycles):
  - RD_EN=1, RD_ADDR = 0..N_ITEMS-1, one address per cycle.
  - After the last address → DRAIN.
- A one-cycle valid pipe (rd_valid plus captured position) follows RD_EN.
  - When rd_valid=1: CMP_EN=1.
  - Update max/idx when RD_DATA > max. The compare is strictly greater and signed.
- Ties keep the lowest index.
- If all scores equal 16'sh8000, the result is 16'sh8000, index 0.
- DRAIN (1 cycle): consumes the last RD_DATA.
- DONE (1 cycle): DONE=1, MAX_VAL/MAX_IDX loaded from the running registers.
- MAX_VAL and MAX_IDX hold until the next DONE. They are not disturbed by CLEAR.
- Reset values:
  - State IDLE.
  - BUSY, DONE, RD_EN, CMP_RST, CMP_EN = 0.
  - RD_ADDR = 0, MAX_VAL = 16'h8000, MAX_IDX = 0.
- RST during any state: IDLE on the next edge, all outputs at reset values, no DONE.
- N_ITEMS=1: READ lasts one cycle. Behaviour is otherwise identical.

## Timing
- START sampled at edge 0 → CLEAR in cycle 1 → READ in cycles 2..N_ITEMS+1 → DRAIN in cycle N_ITEMS+2 → DONE in cycle N_ITEMS+3.
- START-to-DONE latency is N_ITEMS+3 cycles.
- START high during the DONE cycle is not accepted. The earliest restart is START sampled in the IDLE cycle that follows DONE.
- CMP_EN is asserted in cycles 3..N_ITEMS+2.
- Read port contract: fixed 1-cycle latency, no backpressure.

## Configuration
- ARGMAX_ABORT_EN: adds input ABORT (1 bit).
  - ABORT=1 in CLEAR, READ or DRAIN → IDLE on the next edge.
  - No DONE pulse. MAX_VAL/MAX_IDX keep their previous values.
  - RD_EN/CMP_EN drop on the next edge.
  - ABORT in IDLE or DONE has no effect.
- Without the macro: the ABORT port is absent and every accepted run completes.

## Structure
- Shared package npu_argmax_pkg holds:
  - the state encodings (IDLE, CLEAR, READ, DRAIN, DONE);
  - the constant MIN_S16 = 16'sh8000;
  - the default N_ITEMS.
- Sub-module argmax_update holds the compare-and-select register stage (running max, running idx, signed strict compare, clear input).
- The FSM, address counter and valid pipe live in argmax_sequencer.

## Test plan
- N_ITEMS=4, data [5, -3, 12, 7], START pulse → DONE 7 cycles after the START edge, MAX_VAL=12, MAX_IDX=2, RD_ADDR 0,1,2,3 on consecutive cycles.
- Data [9, 9, 2, 9] → MAX_VAL=9, MAX_IDX=0 (lowest index wins ties).
- Data [-5, -2, -9, -2] → MAX_VAL=-2 (16'hFFFE), MAX_IDX=1, confirming the compare is signed.
- All data 16'h8000 → MAX_VAL=16'h8000, MAX_IDX=0. With N_ITEMS=1 and data [-1] → MAX_VAL=-1, MAX_IDX=0, DONE at +4 cycles.
- RST asserted in the cycle RD_ADDR=2 → next cycle IDLE, BUSY=0, MAX_VAL=16'h8000, MAX_IDX=0, no DONE. A new START then completes normally.
- START held high continuously → back-to-back runs, each with DONE at +N_ITEMS+3, and START during BUSY ignored. With ARGMAX_ABORT_EN, ABORT at RD_ADDR=1 → IDLE, no DONE, MAX outputs unchanged.

Source files
------------

// File: rtl/npu_argmax_pkg.sv
// Shared definitions for the argmax sequencer: state encodings, the signed
// 16-bit minimum used to seed the running max, and the default block size.
package npu_argmax_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam logic signed [15:0] MIN_S16     = 16'sh8000;
    localparam int                 N_ITEMS_DEF = 10;

endpackage

// File: rtl/argmax_update.sv
// Running max/index register stage: signed strict-greater compare, so the
// earliest position wins ties. Exposes next-state values so the caller can
// latch a result that includes the final score in the same edge.
module argmax_update
    import npu_argmax_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] data,
    input  logic [ADDR_W-1:0] pos,
    output logic [DATA_W-1:0] max_next,
    output logic [ADDR_W-1:0] idx_next
);

    logic [DATA_W-1:0] run_max_q, run_max_d;
    logic [ADDR_W-1:0] run_idx_q, run_idx_d;

    always_comb begin
        run_max_d = run_max_q;
        run_idx_d = run_idx_q;
        if (clr) begin
            run_max_d = MIN_S16;
            run_idx_d = '0;
        end else if (en && ($signed(data) > $signed(run_max_q))) begin
            run_max_d = data;
            run_idx_d = pos;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_max_q <= MIN_S16;
            run_idx_q <= '0;
        end else begin
            run_max_q <= run_max_d;
            run_idx_q <= run_idx_d;
        end
    end

    assign max_next = run_max_d;
    assign idx_next = run_idx_d;

endmodule

// File: rtl/argmax_sequencer.sv
// Sequences an argmax over N_ITEMS scores from the output buffer and keeps the
// comparator strobes aligned with the read stream. Optional ABORT: ARGMAX_ABORT_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for START
// ST_CLEAR | comparator clear, running max/idx and address reset
// ST_READ  | one buffer read per cycle, addresses 0..N_ITEMS-1
// ST_DRAIN | last read data consumed by the comparator
// ST_DONE  | DONE pulse, MAX_VAL/MAX_IDX freshly loaded
module argmax_sequencer
    import npu_argmax_pkg::*;
#(
    parameter int N_ITEMS = N_ITEMS_DEF,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
`ifdef ARGMAX_ABORT_EN
    input  logic              ABORT,
`endif
    output logic              BUSY,
    output logic              DONE,
    output logic              RD_EN,
    output logic [ADDR_W-1:0] RD_ADDR,
    input  logic [DATA_W-1:0] RD_DATA,
    output logic              CMP_RST,
    output logic              CMP_EN,
    output logic [DATA_W-1:0] MAX_VAL,
    output logic [ADDR_W-1:0] MAX_IDX
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_ITEMS - 1);

    state_e            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              cmp_rst_q, cmp_rst_d;
    logic              cmp_en_q, cmp_en_d;
    logic [ADDR_W-1:0] pos_q, pos_d;
    logic [DATA_W-1:0] max_val_q, max_val_d;
    logic [ADDR_W-1:0] max_idx_q, max_idx_d;

    logic              abort;
    logic [DATA_W-1:0] max_next;
    logic [ADDR_W-1:0] idx_next;

`ifdef ARGMAX_ABORT_EN
    assign abort = ABORT;
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        cmp_rst_d = 1'b0;
        cmp_en_d  = rd_en_q;
        pos_d     = rd_en_q ? rd_addr_q : pos_q;
        max_val_d = max_val_q;
        max_idx_d = max_idx_q;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d   = ST_CLEAR;
                    busy_d    = 1'b1;
                    cmp_rst_d = 1'b1;
                end
            end
            ST_CLEAR: begin
                state_d   = ST_READ;
                rd_en_d   = 1'b1;
                rd_addr_d = '0;
            end
            ST_READ: begin
                if (rd_addr_q == LAST_ADDR) begin
                    state_d = ST_DRAIN;
                end else begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                end
            end
            ST_DRAIN: begin
                // Latch the compare stage's next value so the last score counts.
                state_d   = ST_DONE;
                busy_d    = 1'b0;
                done_d    = 1'b1;
                max_val_d = max_next;
                max_idx_d = idx_next;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (abort && (state_q == ST_CLEAR || state_q == ST_READ || state_q == ST_DRAIN)) begin
            state_d   = ST_IDLE;
            busy_d    = 1'b0;
            done_d    = 1'b0;
            rd_en_d   = 1'b0;
            cmp_rst_d = 1'b0;
            cmp_en_d  = 1'b0;
            max_val_d = max_val_q;
            max_idx_d = max_idx_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            cmp_rst_q <= 1'b0;
            cmp_en_q  <= 1'b0;
            pos_q     <= '0;
            max_val_q <= MIN_S16;
            max_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            cmp_rst_q <= cmp_rst_d;
            cmp_en_q  <= cmp_en_d;
            pos_q     <= pos_d;
            max_val_q <= max_val_d;
            max_idx_q <= max_idx_d;
        end
    end

    argmax_update #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_update (
        .clk      (CLK),
        .rst      (RST),
        .clr      (state_q == ST_CLEAR),
        .en       (cmp_en_q),
        .data     (RD_DATA),
        .pos      (pos_q),
        .max_next (max_next),
        .idx_next (idx_next)
    );

    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign RD_EN   = rd_en_q;
    assign RD_ADDR = rd_addr_q;
    assign CMP_RST = cmp_rst_q;
    assign CMP_EN  = cmp_en_q;
    assign MAX_VAL = max_val_q;
    assign MAX_IDX = max_idx_q;

endmodule

// File: tb/tb_argmax_sequencer.sv
// Self-checking bench for argmax_sequencer: directed and random score blocks
// compared against a plain-arithmetic argmax model. ABORT tested under ARGMAX_ABORT_EN.
module tb_argmax_sequencer;
    import npu_argmax_pkg::*;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, start1, abort;
    logic          busy, done, rd_en, cmp_rst, cmp_en;
    logic [AW-1:0] rd_addr, max_idx;
    logic [DW-1:0] rd_data, max_val;
    logic          busy1, done1, rd_en1, cmp_rst1, cmp_en1;
    logic [AW-1:0] rd_addr1, max_idx1;
    logic [DW-1:0] rd_data1, max_val1;

    logic [DW-1:0] mem [0:255];
    logic [DW-1:0] prev_val;
    logic [AW-1:0] prev_idx;
    int checks   = 0;
    int failures = 0;

    argmax_sequencer #(.N_ITEMS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK(clk), .RST(rst), .START(start),
`ifdef ARGMAX_ABORT_EN
        .ABORT(abort),
`endif
        .BUSY(busy), .DONE(done), .RD_EN(rd_en), .RD_ADDR(rd_addr), .RD_DATA(rd_data),
        .CMP_RST(cmp_rst), .CMP_EN(cmp_en), .MAX_VAL(max_val), .MAX_IDX(max_idx)
    );

    argmax_sequencer #(.N_ITEMS(1), .ADDR_W(AW), .DATA_W(DW)) dut1 (
        .CLK(clk), .RST(rst), .START(start1),
`ifdef ARGMAX_ABORT_EN
        .ABORT(1'b0),
`endif
        .BUSY(busy1), .DONE(done1), .RD_EN(rd_en1), .RD_ADDR(rd_addr1), .RD_DATA(rd_data1),
        .CMP_RST(cmp_rst1), .CMP_EN(cmp_en1), .MAX_VAL(max_val1), .MAX_IDX(max_idx1)
    );

    // Buffer model: 1-cycle read latency, junk on the bus when not reading.
    always @(posedge clk) begin
        rd_data  <= rd_en  ? mem[rd_addr] : DW'($urandom);
        rd_data1 <= rd_en1 ? 16'hFFFF     : DW'($urandom);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void ref_argmax(input int n, output logic [DW-1:0] mv, output logic [AW-1:0] mi);
        int best = -32768;
        int bi   = 0;
        for (int i = 0; i < n; i++) begin
            int v = int'($signed(mem[i]));
            if (v > best) begin
                best = v;
                bi   = i;
            end
        end
        mv = DW'(best);
        mi = AW'(bi);
    endfunction

    task automatic set4(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] c, input logic [DW-1:0] d);
        mem[0] = a; mem[1] = b; mem[2] = c; mem[3] = d;
    endtask

    task automatic run_one(input string tag);
        logic [DW-1:0] ev;
        logic [AW-1:0] ei;
        int c, done_c, nrd, ncmp, addr_ok, first_rd;
        ref_argmax(N, ev, ei);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        c = 1; done_c = -1; nrd = 0; ncmp = 0; addr_ok = 1; first_rd = -1;
        check_eq({tag, "_busy_clear"}, 32'(busy), 1);
        check_eq({tag, "_cmp_rst"}, 32'(cmp_rst), 1);
        while (done_c < 0 && c < 40) begin
            if (rd_en) begin
                if (first_rd < 0) first_rd = c;
                if (int'(rd_addr) != nrd) addr_ok = 0;
                nrd++;
            end
            if (cmp_en) ncmp++;
            if (c == 3) check_eq({tag, "_max_hold"}, 32'(max_val), 32'(prev_val));
            if (done) done_c = c;
            else begin
                @(negedge clk);
                c++;
            end
        end
        check_eq({tag, "_done_cycle"}, 32'(done_c), N + 3);
        check_eq({tag, "_first_rd"}, 32'(first_rd), 2);
        check_eq({tag, "_nreads"}, 32'(nrd), N);
        check_eq({tag, "_addr_seq"}, 32'(addr_ok), 1);
        check_eq({tag, "_ncmp_en"}, 32'(ncmp), N);
        check_eq({tag, "_max_val"}, 32'(max_val), 32'(ev));
        check_eq({tag, "_max_idx"}, 32'(max_idx), 32'(ei));
        prev_val = ev;
        prev_idx = ei;
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, 32'(done), 0);
    endtask

    initial begin
        int c, found, ndone, d1, d2;
        logic [DW-1:0] ev;
        logic [AW-1:0] ei;
        rst = 1'b1; start = 1'b0; start1 = 1'b0; abort = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_rd_en", 32'(rd_en), 0);
        check_eq("rst_cmp", 32'({cmp_rst, cmp_en}), 0);
        check_eq("rst_rd_addr", 32'(rd_addr), 0);
        check_eq("rst_max_val", 32'(max_val), 32'h8000);
        check_eq("rst_max_idx", 32'(max_idx), 0);
        rst = 1'b0;
        prev_val = 16'h8000;
        prev_idx = '0;

        set4(16'd5, -16'sd3, 16'd12, 16'd7);            run_one("basic");
        set4(16'd9, 16'd9, 16'd2, 16'd9);               run_one("ties");
        set4(-16'sd5, -16'sd2, -16'sd9, -16'sd2);       run_one("signed");
        set4(16'h8000, 16'h8000, 16'h8000, 16'h8000);   run_one("all_min");
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < N; i++)
                mem[i] = ($urandom_range(0, 1) == 0) ? DW'($urandom)
                                                     : DW'(int'($urandom_range(0, 4)) - 2);
            run_one($sformatf("rand%0d", r));
        end

        // Single-item instance.
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        c = 1;
        while (!done1 && c < 20) begin
            @(negedge clk);
            c++;
        end
        check_eq("n1_done_cycle", 32'(c), 4);
        check_eq("n1_max_val", 32'(max_val1), 32'hFFFF);
        check_eq("n1_max_idx", 32'(max_idx1), 0);

        // Reset in the middle of a run.
        set4(16'd100, 16'd200, 16'd300, 16'd50);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            if (rd_en && rd_addr == 8'd2) found = 1;
            else @(negedge clk);
        end
        check_eq("rst_mid_reach", 32'(found), 1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_busy", 32'(busy), 0);
        check_eq("rst_mid_rd_en", 32'(rd_en), 0);
        check_eq("rst_mid_max_val", 32'(max_val), 32'h8000);
        check_eq("rst_mid_max_idx", 32'(max_idx), 0);
        rst = 1'b0;
        ndone = 0;
        repeat (10) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check_eq("rst_mid_no_done", 32'(ndone), 0);
        prev_val = 16'h8000;
        prev_idx = '0;
        run_one("after_rst");

        // START held high: back-to-back runs, START ignored while busy.
        set4(16'd1, 16'd40, 16'd3, 16'd40);
        ref_argmax(N, ev, ei);
        @(negedge clk); start = 1'b1;
        @(negedge clk);
        c = 1; d1 = -1; d2 = -1;
        while (d2 < 0 && c < 60) begin
            if (done) begin
                if (d1 < 0) d1 = c; else d2 = c;
                check_eq("held_max_val", 32'(max_val), 32'(ev));
                check_eq("held_max_idx", 32'(max_idx), 32'(ei));
            end
            if (d2 < 0) begin
                @(negedge clk);
                c++;
            end
        end
        start = 1'b0;
        check_eq("held_done1", 32'(d1), N + 3);
        check_eq("held_done2", 32'(d2), 2 * N + 7);
        @(negedge clk);
        check_eq("held_idle", 32'(busy), 0);
        prev_val = ev;
        prev_idx = ei;

`ifdef ARGMAX_ABORT_EN
        set4(16'd700, 16'd800, 16'd900, 16'd5);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            if (rd_en && rd_addr == 8'd1) found = 1;
            else @(negedge clk);
        end
        check_eq("abort_reach", 32'(found), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("abort_busy", 32'(busy), 0);
        check_eq("abort_rd_en", 32'(rd_en), 0);
        check_eq("abort_cmp_en", 32'(cmp_en), 0);
        ndone = 0;
        repeat (10) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check_eq("abort_no_done", 32'(ndone), 0);
        check_eq("abort_max_val", 32'(max_val), 32'(prev_val));
        check_eq("abort_max_idx", 32'(max_idx), 32'(prev_idx));
        run_one("after_abort");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
